// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: holds the PC, issues in-order fetches and buffers
// returned words in a PC-tagged queue that feeds decode over valid/ready.
module if_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_instruction
);

    // Handshakes: a transfer happens in any cycle where valid && ready are both
    // high at the rising edge; valid never depends on ready.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [63:0]       pc;
    logic [63:0]       q_pc    [DEPTH];
    logic [31:0]       q_instr [DEPTH];
    logic [DEPTH-1:0]  q_filled;
    logic [PW-1:0]     alloc_ptr;
    logic [PW-1:0]     fill_ptr;
    logic [PW-1:0]     head_ptr;
    logic [CW-1:0]     used;
    logic [CW-1:0]     drop_cnt;

    logic [CW-1:0]     filled_cnt;
    logic [CW-1:0]     unfilled;
    logic              req_fire;
    logic              pop;
    logic              rsp_drop;
    logic              rsp_fill;
    logic              rsp_stale;
    logic [CW-1:0]     redir_drop;
    logic [CW-1:0]     used_next;

    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CW'(q_filled[i]);
        end
    end

    // Filled flags are only ever set on live entries, so the rest are in flight.
    assign unfilled = used - filled_cnt;

    assign imem_req_valid = !reset && !redirect_valid &&
                            (({1'b0, used} + {1'b0, drop_cnt}) < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign id_valid       = (used != '0) && q_filled[head_ptr];
    assign id_pc          = q_pc[head_ptr];
    assign id_instruction = q_instr[head_ptr];
    assign pop            = id_valid && id_ready && !redirect_valid;

    // A same-cycle response may land in the entry being allocated right now.
    assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill  = imem_rsp_valid && (drop_cnt == '0) &&
                       ((unfilled != '0) || req_fire);
    assign rsp_stale = imem_rsp_valid && ((drop_cnt != '0) || (unfilled != '0));
    assign redir_drop = drop_cnt + unfilled - CW'(rsp_stale);

    assign used_next = used + CW'(req_fire) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            drop_cnt  <= '0;
            q_filled  <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc & ~64'h3;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            drop_cnt  <= redir_drop;
            q_filled  <= '0;
        end else begin
            if (req_fire) begin
                q_pc[alloc_ptr]     <= pc;
                q_filled[alloc_ptr] <= 1'b0;
                alloc_ptr           <= alloc_ptr + 1'b1;
                pc                  <= pc + 64'd4;
            end
            if (pop) begin
                q_filled[head_ptr] <= 1'b0;
                head_ptr           <= head_ptr + 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            // Placed after the allocation so a same-cycle fill wins the flag.
            if (rsp_fill) begin
                q_instr[fill_ptr]  <= imem_rsp_data;
                q_filled[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            used <= used_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a latency-programmable in-order memory
// model plus hand-computed expectations for each scenario.
module tb_if_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    logic [63:0] iss_q[$];
    logic [63:0] pop_pc_q[$];
    logic [31:0] pop_in_q[$];
    int          mem_due[$];
    logic [63:0] mem_addr[$];

    if_fetch_queue #(.DEPTH(2), .RESET_PC(64'h1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instruction (id_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] iss_at(input int i);
        return (i < iss_q.size()) ? iss_q[i] : 64'hffff_ffff_ffff_ffff;
    endfunction

    function automatic logic [63:0] pop_pc_at(input int i);
        return (i < pop_pc_q.size()) ? pop_pc_q[i] : 64'hffff_ffff_ffff_ffff;
    endfunction

    function automatic logic [63:0] pop_in_at(input int i);
        return (i < pop_in_q.size()) ? 64'(pop_in_q[i]) : 64'hffff_ffff_ffff_ffff;
    endfunction

    // One clock cycle: inputs were set at the negedge; sample, drive memory, clock.
    task automatic step();
        #1;
        if (!reset && imem_req_valid && imem_req_ready) begin
            iss_q.push_back(imem_req_addr);
            mem_due.push_back(cyc + lat);
            mem_addr.push_back(imem_req_addr);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr[0][31:0] ^ 32'h13;
            void'(mem_due.pop_front());
            void'(mem_addr.pop_front());
        end
        if (!reset && !redirect_valid && id_valid && id_ready) begin
            pop_pc_q.push_back(id_pc);
            pop_in_q.push_back(id_instruction);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input string tag);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        mem_due.delete();
        mem_addr.delete();
        step();
        #1;
        chk({tag, "_rst_req_valid"}, 64'(imem_req_valid), 64'd0);
        chk({tag, "_rst_id_valid"},  64'(id_valid),       64'd0);
        step();
        reset = 1'b0;
        mem_due.delete();
        mem_addr.delete();
        iss_q.delete();
        pop_pc_q.delete();
        pop_in_q.delete();
        cyc = 0;
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b1;
        @(negedge clk);

        // Streaming with 1-cycle memory latency and decode always ready.
        lat = 1; id_ready = 1'b1;
        do_reset("s1");
        #1;
        chk("s1_first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("s1_first_req_addr",  imem_req_addr,       64'h1000);
        run(8);
        chk("s1_iss0", iss_at(0), 64'h1000);
        chk("s1_iss1", iss_at(1), 64'h1004);
        chk("s1_iss2", iss_at(2), 64'h1008);
        chk("s1_pop0_pc", pop_pc_at(0), 64'h1000);
        chk("s1_pop1_pc", pop_pc_at(1), 64'h1004);
        chk("s1_pop2_pc", pop_pc_at(2), 64'h1008);
        chk("s1_pop0_in", pop_in_at(0), 64'h1013);
        chk("s1_pop1_in", pop_in_at(1), 64'h1017);
        chk("s1_pop2_in", pop_in_at(2), 64'h101b);

        // Decode stalled for 5 cycles: queue fills at 2, head held stable.
        lat = 1; id_ready = 1'b0;
        do_reset("s2");
        run(5);
        #1;
        chk("s2_iss_count", 64'(iss_q.size()), 64'd2);
        chk("s2_full_req_valid", 64'(imem_req_valid), 64'd0);
        chk("s2_hold_id_valid", 64'(id_valid), 64'd1);
        chk("s2_hold_id_pc", id_pc, 64'h1000);
        chk("s2_hold_id_in", 64'(id_instruction), 64'h1013);
        id_ready = 1'b1;
        run(3);
        chk("s2_resume_iss", iss_at(2), 64'h1008);
        chk("s2_pop0_pc", pop_pc_at(0), 64'h1000);
        chk("s2_pop1_pc", pop_pc_at(1), 64'h1004);

        // Redirect to an unaligned target with two requests in flight (latency 3).
        lat = 3; id_ready = 1'b1;
        do_reset("s3");
        run(2);
        redirect_valid = 1'b1; redirect_pc = 64'h2002;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s3_drop_gates_req", 64'(imem_req_valid), 64'd0);
        step();
        #1;
        chk("s3_req_valid_after_drop", 64'(imem_req_valid), 64'd1);
        chk("s3_req_addr", imem_req_addr, 64'h2000);
        step();
        run(5);
        chk("s3_pop0_pc", pop_pc_at(0), 64'h2000);
        chk("s3_pop0_in", pop_in_at(0), 64'h2013);
        chk("s3_pop_count", 64'(pop_pc_q.size()), 64'd2);

        // Redirect coinciding with a response and a ready decode stage.
        lat = 1; id_ready = 1'b1;
        do_reset("s4");
        run(2);
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        #1;
        chk("s4_redir_req_valid", 64'(imem_req_valid), 64'd0);
        chk("s4_pre_id_valid", 64'(id_valid), 64'd1);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s4_post_id_valid", 64'(id_valid), 64'd0);
        chk("s4_post_req_valid", 64'(imem_req_valid), 64'd1);
        chk("s4_post_req_addr", imem_req_addr, 64'h3000);
        step();
        run(4);
        chk("s4_pop0_pc", pop_pc_at(0), 64'h3000);
        chk("s4_pop0_in", pop_in_at(0), 64'h3013);
        chk("s4_pop_count", 64'(pop_pc_q.size()), 64'd2);

        // Back-to-back redirects with one request outstanding (latency 3).
        lat = 3; id_ready = 1'b1;
        do_reset("s5");
        run(1);
        redirect_valid = 1'b1; redirect_pc = 64'h4000;
        #1;
        chk("s5_redir1_req_valid", 64'(imem_req_valid), 64'd0);
        step();
        redirect_pc = 64'h5000;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s5_req0_valid", 64'(imem_req_valid), 64'd1);
        chk("s5_req0_addr", imem_req_addr, 64'h5000);
        step();
        #1;
        chk("s5_req1_valid", 64'(imem_req_valid), 64'd1);
        chk("s5_req1_addr", imem_req_addr, 64'h5004);
        step();
        run(4);
        chk("s5_iss1", iss_at(1), 64'h5000);
        chk("s5_pop0_pc", pop_pc_at(0), 64'h5000);
        chk("s5_pop0_in", pop_in_at(0), 64'h5013);

        // Reset while the queue is full.
        lat = 1; id_ready = 1'b0;
        do_reset("s6a");
        run(4);
        #1;
        chk("s6_full_id_valid", 64'(id_valid), 64'd1);
        do_reset("s6b");
        #1;
        chk("s6_after_req_valid", 64'(imem_req_valid), 64'd1);
        chk("s6_after_req_addr", imem_req_addr, 64'h1000);
        chk("s6_after_id_valid", 64'(id_valid), 64'd0);
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
